// File: rtl/trinity_bus_arb_if.sv
// rtl/trinity_bus_arb_if.sv - request/grant bus between three requesters and the arbiter

interface trinity_bus_arb_if;

    // Requester side: per-requester request, end-of-packet flag and payload
    logic [2:0] req;
    logic [2:0] last;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [7:0] data2;

    // Downstream acceptance of the beat currently on the bus
    logic       bus_ready;

    // Arbiter side: grant, owner index, muxed beat and running beat count
    logic [2:0] gnt;
    logic [1:0] owner;
    logic [7:0] bus_out;
    logic       bus_valid;
    logic [7:0] xfer_cnt;

    // Requesters and the downstream sink
    modport master (
        output req, last, data0, data1, data2, bus_ready,
        input  gnt, owner, bus_out, bus_valid, xfer_cnt
    );

    // The arbiter
    modport slave (
        input  req, last, data0, data1, data2, bus_ready,
        output gnt, owner, bus_out, bus_valid, xfer_cnt
    );

endinterface

// File: rtl/trinity_bus_arb.sv
// rtl/trinity_bus_arb.sv - three-way round-robin bus arbiter with per-grant beat limit

module trinity_bus_arb #(
    parameter int MAX_HOLD = 4,
    parameter int NREQ     = 3
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    trinity_bus_arb_if.slave   bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);
    localparam logic [1:0] NO_OWNER   = 2'd3;

    state_t          state_q, state_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [3:0]      beat_q, beat_d;
    logic [7:0]      xfer_q, xfer_d;

    logic [NREQ-1:0] req_w;
    logic            own_req;
    logic            own_last;
    logic [7:0]      own_data;
    logic [1:0]      pick_first, pick_second, pick_third;
    logic [1:0]      winner;
    logic            bus_valid_w;
    logic [7:0]      bus_out_w;
    logic            accept;
    logic            hold_hit;
    logic            release_w;

    assign req_w = bus.req;

    // Route the owner's request, last flag and payload; non-owners are never looked at
    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        own_data = 8'h00;
        case (owner_q)
            2'd0: begin
                own_req  = req_w[0];
                own_last = bus.last[0];
                own_data = bus.data0;
            end
            2'd1: begin
                own_req  = req_w[1];
                own_last = bus.last[1];
                own_data = bus.data1;
            end
            2'd2: begin
                own_req  = req_w[2];
                own_last = bus.last[2];
                own_data = bus.data2;
            end
            default: begin
                own_req  = 1'b0;
                own_last = 1'b0;
                own_data = 8'h00;
            end
        endcase
    end

    // Round-robin search order begins one past the previous owner
    always_comb begin
        pick_first  = 2'd0;
        pick_second = 2'd1;
        pick_third  = 2'd2;
        case (rr_ptr_q)
            2'd0: begin
                pick_first  = 2'd1;
                pick_second = 2'd2;
                pick_third  = 2'd0;
            end
            2'd1: begin
                pick_first  = 2'd2;
                pick_second = 2'd0;
                pick_third  = 2'd1;
            end
            default: begin
                pick_first  = 2'd0;
                pick_second = 2'd1;
                pick_third  = 2'd2;
            end
        endcase

        winner = NO_OWNER;
        if (req_w[pick_first]) begin
            winner = pick_first;
        end else if (req_w[pick_second]) begin
            winner = pick_second;
        end else if (req_w[pick_third]) begin
            winner = pick_third;
        end
    end

    // Release on a dropped request, or on an accepted beat that ends the packet or the hold window
    always_comb begin
        hold_hit  = (beat_q + 4'd1) == HOLD_LIMIT;
        release_w = (state_q == S_OWN) &&
                    (!own_req || (accept && (own_last || hold_hit)));
    end

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: any request wins a grant, any release returns to idle for one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_w != '0) begin
                    state_d = S_OWN;
                end
            end
            S_OWN: begin
                if (release_w) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: the beat is valid only while the owner keeps requesting
    always_comb begin
        bus_valid_w = 1'b0;
        bus_out_w   = 8'h00;
        if (state_q == S_OWN) begin
            bus_valid_w = own_req;
            bus_out_w   = own_data;
        end
        accept = bus_valid_w && bus.bus_ready;
    end

    // Grant, owner, round-robin pointer and counters for the next edge
    always_comb begin
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        xfer_d   = accept ? xfer_q + 8'd1 : xfer_q;
        case (state_q)
            S_IDLE: begin
                if (winner != NO_OWNER) begin
                    gnt_d   = 3'b001 << winner;
                    owner_d = winner;
                    beat_d  = 4'd0;
                end
            end
            S_OWN: begin
                if (release_w) begin
                    gnt_d    = 3'b000;
                    owner_d  = NO_OWNER;
                    rr_ptr_d = owner_q;
                end else if (accept) begin
                    beat_d = beat_q + 4'd1;
                end
            end
            default: begin
                gnt_d   = 3'b000;
                owner_d = NO_OWNER;
            end
        endcase
    end

    // Datapath registers; reset points rr_ptr at requester 2 so core wins first
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            gnt_q    <= 3'b000;
            owner_q  <= NO_OWNER;
            rr_ptr_q <= 2'd2;
            beat_q   <= 4'd0;
            xfer_q   <= 8'd0;
        end else begin
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            xfer_q   <= xfer_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.owner     = owner_q;
    assign bus.bus_out   = bus_out_w;
    assign bus.bus_valid = bus_valid_w;
    assign bus.xfer_cnt  = xfer_q;

    // Grant is one-hot or empty, and empty exactly when there is no owner
    a_gnt_onehot: assert property (@(posedge sys_clk) disable iff (sys_rst)
        $onehot0(gnt_q));
    a_gnt_owner: assert property (@(posedge sys_clk) disable iff (sys_rst)
        ((gnt_q == 3'b000) == (owner_q == NO_OWNER)));
    a_gnt_state: assert property (@(posedge sys_clk) disable iff (sys_rst)
        ((gnt_q != 3'b000) == (state_q == S_OWN)));

endmodule

// File: doc/trinity_bus_arb.md
TRINITY_BUS_ARB -- requirements
Module: trinity_bus_arb

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, meaning the maximum number of accepted beats per grant (legal range 1..15).
REQ-002 SHALL have parameter NREQ, fixed at 3, meaning the requester count; index 0 is core, 1 is mem, 2 is router.
REQ-003 SHALL have port sys_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  input  3  per-requester bus request, held high while the requester has data.
REQ-006 SHALL have port last  input  3  per-requester end-of-packet flag, qualified by that requester's beat.
REQ-007 SHALL have port data0/data1/data2  input  8 each  per-requester payload byte.
REQ-008 SHALL have port bus_ready  input  1  downstream acceptance of the current beat.
REQ-009 SHALL have port gnt  output  3  one-hot grant, all zero when no owner.
REQ-010 SHALL have port owner  output  2  index of the current owner, 2'd3 when idle.
REQ-011 SHALL have port bus_out  output  8  payload from the owner; 8'h00 when idle.
REQ-012 SHALL have port bus_valid  output  1  beat valid, equal to req[owner] while a grant is held, 0 otherwise.
REQ-013 SHALL have port xfer_cnt  output  8  count of accepted beats since reset, wrapping at 255->0.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and OWN.
REQ-015 SHALL, in IDLE with req != 0, select a winner by round-robin and enter OWN on the next edge with gnt and owner registered.
REQ-016 SHALL search round-robin starting at rr_ptr+1 mod 3, where rr_ptr is the index of the previous owner.
REQ-017 SHALL NOT let gnt change within a grant; the grant latency from the req rising edge in IDLE is exactly 1 cycle.
REQ-018 SHALL count a beat as accepted when bus_valid && bus_ready are both high on a rising edge.
REQ-019 SHALL increment a 4-bit beat counter on each accepted beat and clear it on entry to OWN.
REQ-020 SHALL release the grant on the edge at which an accepted beat has last[owner]=1, or at which the beat count reaches MAX_HOLD.
REQ-021 SHALL release the grant on the first edge at which req[owner]=0, whether or not a beat is pending.
REQ-022 SHALL, on release, set rr_ptr to owner, return to IDLE, and deassert gnt and bus_valid; every release causes exactly one idle cycle.
REQ-023 SHALL ignore last[i] and data from requesters that are not the owner.
REQ-024 SHALL, when last and MAX_HOLD expiry coincide, perform a single release with no double count.
REQ-025 SHALL leave the beat counter unchanged while bus_valid=1 and bus_ready=0; the beat stays on the bus and the grant is held indefinitely.
REQ-026 SHALL drive bus_out combinationally from the data port selected by the registered owner.
REQ-027 SHALL increment xfer_cnt once per accepted beat, modulo 256.

Reset
REQ-028 SHALL, when sys_rst=1 at an edge, set state=IDLE, gnt=0, owner=3, bus_valid=0, bus_out=8'h00, beat counter=0, xfer_cnt=0, rr_ptr=2, regardless of any grant in progress.
REQ-029 SHALL, since rr_ptr=2 after reset, make requester 0 (core) the winner of the first arbitration after reset when it requests.
REQ-030 SHALL ignore all inputs during reset and begin arbitration on the first edge with sys_rst=0.

Verification
REQ-031 SHALL be verified with: after reset, req=3'b111 with bus_ready=1 and no last -> grant order 0,1,2,0, each grant lasting 4 beats followed by 1 idle cycle; xfer_cnt=12 after three grants.
REQ-032 SHALL be verified with: req[1] only, last[1] on beat 2, data1=8'hA5 -> gnt=3'b010 for 2 beats, bus_out=8'hA5, then IDLE, owner=3.
REQ-033 SHALL be verified with: owner 0 and bus_ready=0 for 10 cycles -> gnt held, beat counter frozen, bus_valid=1; after ready, 4 beats complete.
REQ-034 SHALL be verified with: req[2] dropped mid-grant after 1 beat -> release on that edge; next winner is 0 if it requests.
REQ-035 SHALL be verified with: sys_rst pulsed during owner 1's beat 3 -> next cycle gnt=0, xfer_cnt=0; with req=3'b011 the first grant goes to 0.
REQ-036 SHALL be verified with: 260 accepted beats -> xfer_cnt=4.
